// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter and related
// shared-resource arbiters.
package uart_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned RR_MAX = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    DRAIN
  } arb_state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_sel_t;

  // First set bit of valid scanning ptr, ptr+1, ... modulo n (n <= RR_MAX).
  function automatic rr_sel_t rr_pick(input logic [RR_MAX-1:0] valid,
                                      input logic [2:0]        ptr,
                                      input int unsigned       n);
    rr_sel_t     sel;
    int unsigned c;
    sel = '0;
    for (int unsigned k = 0; k < RR_MAX; k++) begin
      c = (32'(ptr) + k) % n;
      if (k < n && !sel.found && valid[c[2:0]]) begin
        sel.found = 1'b1;
        sel.idx   = c[2:0];
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Pure combinational round-robin priority scan over N requesters.
module rr_picker
  import uart_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         valid,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] idx,
  output logic                 found
);

  localparam int unsigned IW = $clog2(N);

  rr_sel_t sel;

  always_comb begin
    sel   = rr_pick(RR_MAX'(valid), 3'(ptr), N);
    found = sel.found;
    idx   = IW'(sel.idx);
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one uart_tx between N_REQ
// byte-stream requesters; paced solely by the transmitter's busy flag.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned STALL_LIMIT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [8*N_REQ-1:0]       req_data,
  input  logic [N_REQ-1:0]         req_last,
  output logic [N_REQ-1:0]         req_ready,
  output logic [7:0]               tx_data,
  output logic                     tx_en,
  input  logic                     tx_busy,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     grant_active,
  output logic                     stall_abort
);

  localparam int unsigned GW = $clog2(N_REQ);
  localparam int unsigned SW = $clog2(STALL_LIMIT);
  localparam logic [SW-1:0] STALL_MAX = SW'(STALL_LIMIT - 1);
  localparam logic [GW-1:0] LAST_ID   = GW'(N_REQ - 1);

  arb_state_t state, state_nxt;

  logic [GW-1:0]     rr_ptr;
  logic [GW-1:0]     pick_idx;
  logic              pick_found;
  logic [GW-1:0]     next_ptr;
  logic [SW-1:0]     stall_cnt;
  logic [BYTE_W-1:0] hold_data;
  logic              hold_last;
  logic [BYTE_W-1:0] data_arr [N_REQ];
  logic              xfer;
  logic              stall_hit;

  for (genvar i = 0; i < N_REQ; i++) begin : g_split
    assign data_arr[i] = req_data[i*BYTE_W +: BYTE_W];
  end

  rr_picker #(.N(N_REQ)) u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign xfer      = (state == LOAD) && req_valid[grant_id];
  assign stall_hit = (state == LOAD) && !req_valid[grant_id] && (stall_cnt == STALL_MAX);
  assign next_ptr  = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
  assign tx_data   = hold_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // tx_en is held through SEND until busy is seen, covering uart_tx's re-arm gap.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    tx_en     = 1'b0;
    case (state)
      IDLE:  if (pick_found) state_nxt = LOAD;
      LOAD: begin
        req_ready[grant_id] = 1'b1;
        if (xfer)           state_nxt = SEND;
        else if (stall_hit) state_nxt = IDLE;
      end
      SEND: begin
        tx_en = 1'b1;
        if (tx_busy) state_nxt = DRAIN;
      end
      DRAIN: if (!tx_busy) state_nxt = hold_last ? IDLE : LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr       <= '0;
      grant_id     <= '0;
      grant_active <= 1'b0;
      stall_abort  <= 1'b0;
      stall_cnt    <= '0;
      hold_data    <= '0;
      hold_last    <= 1'b0;
    end else begin
      stall_abort <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_id     <= pick_idx;
            grant_active <= 1'b1;
            stall_cnt    <= '0;
          end
        end
        LOAD: begin
          if (xfer) begin
            hold_data <= data_arr[grant_id];
            hold_last <= req_last[grant_id];
            stall_cnt <= '0;
          end else if (stall_hit) begin
            stall_abort  <= 1'b1;
            grant_active <= 1'b0;
            rr_ptr       <= next_ptr;
            stall_cnt    <= '0;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (!tx_busy) begin
            if (hold_last) begin
              grant_active <= 1'b0;
              rr_ptr       <= next_ptr;
            end else begin
              stall_cnt <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter with a behavioural uart_tx
// and a packet-level round-robin reference model.
module tb_uart_tx_arbiter;

  localparam int N     = 4;
  localparam int STALL = 8;
  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data  = '0;
  logic [N-1:0]   req_last  = '0;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_data;
  logic           tx_en;
  logic           tx_busy = 1'b0;
  logic [1:0]     grant_id;
  logic           grant_active;
  logic           stall_abort;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .STALL_LIMIT(STALL)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_data      (tx_data),
    .tx_en        (tx_en),
    .tx_busy      (tx_busy),
    .grant_id     (grant_id),
    .grant_active (grant_active),
    .stall_abort  (stall_abort)
  );

  typedef struct {
    logic [7:0] d;
    logic       l;
  } item_t;

  typedef struct {
    int unsigned g;
    logic [7:0]  d;
  } exp_t;

  item_t       src_q [N][$];
  item_t       stage [N][$];
  exp_t        exp_q [$];
  int unsigned n_checks    = 0;
  int unsigned n_fail      = 0;
  int unsigned aborts_exp  = 0;
  int unsigned aborts_seen = 0;
  int unsigned model_rr    = 0;
  int unsigned busy_cnt    = 0;
  int unsigned gap         = 0;
  int unsigned cyc         = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit srcs_empty();
    bit e = 1'b1;
    for (int i = 0; i < N; i++) if (src_q[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  // Moves staged packets to the sources and predicts the byte order on the line:
  // whole packets, round-robin from the last grantee + 1, abort if a packet runs dry.
  task automatic launch();
    item_t       cp [N][$];
    item_t       it;
    int unsigned g;
    int unsigned c;
    bit          found;
    bit          ended;
    for (int i = 0; i < N; i++) begin
      foreach (stage[i][k]) src_q[i].push_back(stage[i][k]);
      stage[i].delete();
      cp[i] = src_q[i];
    end
    while (1) begin
      found = 1'b0;
      g     = 0;
      for (int k = 0; k < N; k++) begin
        c = (model_rr + k) % N;
        if (!found && cp[c].size() > 0) begin
          found = 1'b1;
          g     = c;
        end
      end
      if (!found) break;
      ended = 1'b0;
      while (cp[g].size() > 0 && !ended) begin
        it = cp[g].pop_front();
        exp_q.push_back('{g, it.d});
        ended = it.l;
      end
      if (!ended) aborts_exp++;
      model_rr = (g + 1) % N;
    end
  endtask

  task automatic stage_byte(input int r, input logic [7:0] d, input logic l);
    item_t it;
    it.d = d;
    it.l = l;
    stage[r].push_back(it);
  endtask

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    for (int k = 0; k < 6000 && !done; k++) begin
      @(negedge clk);
      done = exp_q.size() == 0 && !grant_active && busy_cnt == 0 && gap == 0 && srcs_empty();
    end
    chk({"drain_", tag}, done, 1);
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) src_q[i].delete();
    exp_q.delete();
    model_rr = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_all();
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Source drivers: present queue heads, retire bytes that handshook.
  initial begin : drive
    logic [N-1:0] fire;
    item_t        tmp;
    forever begin
      @(negedge clk);
      fire = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (!rst && fire[i] && src_q[i].size() > 0) tmp = src_q[i].pop_front();
        if (!rst && src_q[i].size() > 0) begin
          tmp = src_q[i][0];
          req_valid[i]       = 1'b1;
          req_data[i*8 +: 8] = tmp.d;
          req_last[i]        = tmp.l;
        end else begin
          req_valid[i]       = 1'b0;
          req_data[i*8 +: 8] = 8'h00;
          req_last[i]        = 1'b0;
        end
      end
    end
  end

  // Behavioural uart_tx plus scoreboard monitor on every accepted frame.
  initial begin : monitor
    logic        en_s;
    logic        prev_en = 1'b0;
    logic        taken   = 1'b0;
    logic [7:0]  d_s;
    logic [7:0]  prev_d  = 8'h00;
    int unsigned g_s;
    exp_t        e;
    forever begin
      @(negedge clk);
      en_s = tx_en;
      d_s  = tx_data;
      g_s  = grant_id;
      if (!rst) begin
        if (stall_abort) aborts_seen++;
        if (prev_en && !en_s) chk("en_drop_before_accept", taken, 1);
        if (prev_en && en_s && !taken) chk("tx_data_hold", d_s, prev_d);
      end
      if (!en_s) taken = 1'b0;
      prev_en = rst ? 1'b0 : en_s;
      prev_d  = d_s;
      @(posedge clk);
      #1;
      if (rst) begin
        busy_cnt = 0;
        gap      = 0;
        taken    = 1'b0;
        prev_en  = 1'b0;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) gap = CPB - 1;
      end else if (gap > 0) begin
        gap--;
      end else if (en_s && !taken) begin
        taken    = 1'b1;
        busy_cnt = FRAME;
        chk("frame_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("frame_data", d_s, e.d);
          chk("frame_grant", g_s, e.g);
        end
      end
      tx_busy = (busy_cnt > 0);
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int unsigned lcyc;
    bit          seen;
    int          any;

    repeat (3) @(negedge clk);
    chk("rst_tx_en", tx_en, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_grant_active", grant_active, 0);
    chk("rst_stall_abort", stall_abort, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_grant_id", grant_id, 0);
    rst = 1'b0;

    // Latency from idle: grant, accept, tx_en, busy.
    @(negedge clk);
    stage_byte(0, 8'hA5, 1'b1);
    launch();
    @(negedge clk);
    chk("lat_c0_grant_active", grant_active, 0);
    chk("lat_c0_ready", req_ready, 0);
    @(negedge clk);
    chk("lat_c1_grant_active", grant_active, 1);
    chk("lat_c1_ready", req_ready, 4'b0001);
    chk("lat_c1_grant_id", grant_id, 0);
    @(negedge clk);
    chk("lat_c2_tx_en", tx_en, 1);
    chk("lat_c2_tx_data", tx_data, 8'hA5);
    @(negedge clk);
    chk("lat_c3_tx_busy", tx_busy, 1);
    chk("lat_c3_tx_en", tx_en, 1);
    @(negedge clk);
    chk("lat_c4_tx_en", tx_en, 0);
    wait_idle("latency");

    // Single packet on requester 2, then a probe showing the pointer moved to 3.
    @(negedge clk);
    stage_byte(2, 8'h48, 1'b0);
    stage_byte(2, 8'h69, 1'b1);
    launch();
    wait_idle("single");
    @(negedge clk);
    stage_byte(0, 8'h11, 1'b1);
    stage_byte(3, 8'h33, 1'b1);
    launch();
    wait_idle("rr_probe");

    // Contention between 0 and 1 from a fresh pointer.
    do_reset();
    @(negedge clk);
    stage_byte(0, 8'hA0, 1'b0);
    stage_byte(0, 8'hA1, 1'b1);
    stage_byte(1, 8'hB0, 1'b0);
    stage_byte(1, 8'hB1, 1'b1);
    launch();
    wait_idle("contention");

    // Fairness: two single-byte packets per requester.
    do_reset();
    @(negedge clk);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) stage_byte(i, 8'(16 * i + k), 1'b1);
    launch();
    wait_idle("fairness");

    // Stall: requester 1 runs dry mid-packet while requester 3 waits.
    do_reset();
    @(negedge clk);
    stage_byte(1, 8'h5A, 1'b0);
    stage_byte(3, 8'hC3, 1'b1);
    launch();
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin @(negedge clk); seen = tx_en; end
    chk("stall_wait_tx_en_high", seen, 1);
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin @(negedge clk); seen = !tx_en; end
    chk("stall_wait_tx_en_low", seen, 1);
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin @(negedge clk); seen = (req_ready == 4'b0010); end
    chk("stall_wait_load", seen, 1);
    lcyc = cyc;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = stall_abort;
      if (!seen) chk("stall_ready_held", req_ready, 4'b0010);
    end
    chk("stall_abort_seen", seen, 1);
    chk("stall_abort_delay", cyc - lcyc, STALL);
    chk("stall_grant_dropped", grant_active, 0);
    wait_idle("stall");

    // Reset while a byte is being offered; the byte is abandoned.
    do_reset();
    @(negedge clk);
    stage_byte(2, 8'hE0, 1'b0);
    stage_byte(2, 8'hE1, 1'b0);
    stage_byte(2, 8'hE2, 1'b1);
    launch();
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin @(posedge clk); #2; seen = tx_en; end
    chk("rmid_wait_tx_en", seen, 1);
    rst = 1'b1;
    #1;
    chk("rmid_tx_en", tx_en, 0);
    chk("rmid_req_ready", req_ready, 0);
    chk("rmid_grant_active", grant_active, 0);
    chk("rmid_stall_abort", stall_abort, 0);
    chk("rmid_tx_data", tx_data, 0);
    chk("rmid_grant_id", grant_id, 0);
    clear_all();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    stage_byte(3, 8'hD3, 1'b1);
    stage_byte(1, 8'hD1, 1'b1);
    launch();
    wait_idle("after_reset");

    // Randomized rounds of mixed packet counts and lengths.
    for (int r = 0; r < 6; r++) begin
      @(negedge clk);
      any = 0;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(1, 0) == 1) begin
          for (int p = 0; p < int'($urandom_range(2, 1)); p++) begin
            int len = int'($urandom_range(3, 1));
            for (int b = 0; b < len; b++) stage_byte(i, 8'($urandom), b == len - 1);
            any++;
          end
        end
      end
      if (any == 0) stage_byte(r % N, 8'($urandom), 1'b1);
      launch();
      wait_idle("random");
    end

    chk("stall_abort_count", aborts_seen, aborts_exp);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
